// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response transmitter.
//   RESP_W               : width of one PUF response word
//   CLKS_PER_BIT_DEFAULT : 100 MHz / 115200 baud
//   tx_state_t           : serialiser states (PARITY only used when
//                          PUF_RESP_TX_PARITY_EN is defined)
package puf_pkg;

   localparam int RESP_W               = 8;
   localparam int CLKS_PER_BIT_DEFAULT = 868;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

endpackage

// File: rtl/puf_resp_fifo.sv
// Small synchronous FIFO holding captured responses until the UART
// serialiser is free.
// Ports:
//   clk, rst (async, active low)
//   push/wr_data : enqueue request; accepted when not full, or when full
//                  and a pop happens in the same cycle
//   pop          : dequeue request (ignored when empty)
//   rd_data      : current head word (combinational read)
//   full, empty  : occupancy flags
//   count        : occupancy, 0..DEPTH
module puf_resp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty;
      // A full FIFO can still take a word if the head leaves this cycle.
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/puf_response_tx.sv
// Consumer end of the PUF response path. Captures each completed response
// once (rising edge of ready_to_read), queues it, and sends it to the host
// as a UART frame, LSB first.
// Ports:
//   clk, rst (async, active low)
//   response, ready_to_read : word and completion flag from response buffer
//   tx         : UART serial output, idle high, registered
//   busy       : frame in flight or queue non-empty
//   overflow   : sticky, a capture was dropped because the queue was full
//   fifo_count : queue occupancy
// Build option: define PUF_RESP_TX_PARITY_EN for 8E1 framing (adds an even
// parity bit); otherwise frames are 8N1.
module puf_response_tx
   import puf_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [RESP_W-1:0]             response,
   input  logic                          ready_to_read,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_t          state_q, state_d;
   logic [BAUD_W-1:0]  baud_q, baud_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [RESP_W-1:0]  shreg_q, shreg_d;
   logic               tx_q, tx_d;
   logic               rdy_q, rdy_d;
   logic               armed_q, armed_d;
   logic               overflow_q, overflow_d;

   logic               capture, pop, baud_last;
   logic               fifo_full, fifo_empty;
   logic [RESP_W-1:0]  fifo_rd_data;

   // armed_q is low only in the first cycle after reset release, so a
   // ready_to_read already high at release is not mistaken for an edge.
   assign capture = ready_to_read & ~rdy_q & armed_q;

   puf_resp_fifo #(
      .WIDTH (RESP_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (capture),
      .wr_data (response),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         shreg_q    <= '0;
         tx_q       <= 1'b1;
         rdy_q      <= 1'b0;
         armed_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         shreg_q    <= shreg_d;
         tx_q       <= tx_d;
         rdy_q      <= rdy_d;
         armed_q    <= armed_d;
         overflow_q <= overflow_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      pop       = 1'b0;
      baud_last = (baud_q == BAUD_LAST);
      rdy_d     = ready_to_read;
      armed_d   = 1'b1;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_d = fifo_rd_data;
               state_d = START;
            end
         end
         START: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_last) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_last) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
`ifdef PUF_RESP_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef PUF_RESP_TX_PARITY_EN
         PARITY: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_last) begin
               baud_d  = '0;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            baud_d = baud_q + BAUD_W'(1);
            if (baud_last) begin
               baud_d  = '0;
               state_d = IDLE;
            end
         end
         default: begin
            baud_d  = '0;
            state_d = IDLE;
         end
      endcase
      // A word that arrives while the queue is full and not draining is lost.
      overflow_d = overflow_q | (capture & fifo_full & ~pop);
   end

   // Output logic: tx level for the current state, registered into tx_q so
   // the pin lags the state by one cycle.
   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_q[bit_idx_q];
`ifdef PUF_RESP_TX_PARITY_EN
         PARITY:  tx_d = ^shreg_q;
`endif
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   assign tx       = tx_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != IDLE) | (|fifo_count);

endmodule

// File: tb/tb_puf_response_tx.sv
module tb_puf_response_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef PUF_RESP_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int NSMP = NBITS * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ready_to_read = 1'b0;
   logic [7:0] response = 8'h00;
   logic       tx, busy, overflow;
   logic [2:0] fifo_count;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   logic [7:0] sb_q[$];          // expected frame payloads, in order
   int         frame_starts[$];  // cycle of first start-bit sample per frame
   logic       parity_seen[$];

   puf_response_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .response      (response),
      .ready_to_read (ready_to_read),
      .tx            (tx),
      .busy          (busy),
      .overflow      (overflow),
      .fifo_count    (fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: decodes frames from tx at negedges and checks them against
   // the scoreboard. A reset during a frame discards it.
   logic       smp [NSMP];
   int         mon_start;
   bit         mon_abort;
   bit         mon_ok;
   logic [7:0] mon_data;
   logic [7:0] mon_exp;

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && tx === 1'b0) begin
            mon_start = cyc;
            smp[0]    = tx;
            mon_abort = 1'b0;
            for (int j = 1; j < NSMP; j++) begin
               @(negedge clk);
               if (rst !== 1'b1) begin
                  mon_abort = 1'b1;
                  break;
               end
               smp[j] = tx;
            end
            if (!mon_abort) begin
               mon_ok = 1'b1;
               for (int g = 0; g < NBITS; g++)
                  for (int s = 1; s < CPB; s++)
                     if (smp[g*CPB+s] !== smp[g*CPB]) mon_ok = 1'b0;
               if (smp[(NBITS-1)*CPB] !== 1'b1) mon_ok = 1'b0;
               for (int i = 0; i < 8; i++) mon_data[i] = smp[(i+1)*CPB];
               frame_starts.push_back(mon_start);
               $display("frame data=%02h start_cycle=%0d", mon_data, mon_start);
               check("frame_timing", {31'd0, mon_ok}, 32'd1);
`ifdef PUF_RESP_TX_PARITY_EN
               parity_seen.push_back(smp[9*CPB]);
               check("frame_parity", {31'd0, smp[9*CPB]}, {31'd0, ^mon_data});
`endif
               if (sb_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_frame: got %02h expected no frame", mon_data);
               end else begin
                  mon_exp = sb_q.pop_front();
                  check("frame_data", {24'd0, mon_data}, {24'd0, mon_exp});
               end
            end
         end
      end
   end

   task automatic send_one(input logic [7:0] b, output int k);
      @(posedge clk); #1;
      k = cyc;
      response = b;
      ready_to_read = 1'b1;
      sb_q.push_back(b);
      $display("capture %02h at cycle %0d", b, k + 1);
      @(posedge clk); #1;
      ready_to_read = 1'b0;
      response = 8'h00;
   endtask

   // Burst of n captures spaced 2 cycles apart; only the first n_keep are
   // expected on the wire.
   task automatic send_burst(input logic [7:0] base, input int n, input int n_keep, output int k);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (i == 0) k = cyc;
         response = base + 8'(i);
         ready_to_read = 1'b1;
         if (i < n_keep) sb_q.push_back(base + 8'(i));
         $display("capture %02h at cycle %0d", base + 8'(i), cyc + 1);
         @(posedge clk); #1;
         ready_to_read = 1'b0;
         response = 8'h00;
      end
   endtask

   task automatic busy_drop(output int t);
      t = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            t = cyc;
            break;
         end
      end
   endtask

   task automatic wait_done(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (busy === 1'b0 && sb_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
      check({name, "_drain"}, {31'd0, done}, 32'd1);
   endtask

   initial begin : stim
      int  k, t, nf, maxc;
      bit  seen;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_overflow", {31'd0, overflow}, 32'd0);
      check("reset_count", {29'd0, fifo_count}, 32'd0);

      // ready_to_read already high when reset releases: no capture
      ready_to_read = 1'b1;
      response = 8'hEE;
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      check("release_count", {29'd0, fifo_count}, 32'd0);
      check("release_busy", {31'd0, busy}, 32'd0);
      ready_to_read = 1'b0;
      response = 8'h00;
      repeat (2) @(negedge clk);

      // Single capture 8'hA5: capture edge k+1, pop k+2, tx low sampled
      // after k+3, 40-cycle frame returns FSM to IDLE at edge k+42.
      nf = frame_starts.size();
      send_one(8'hA5, k);
      check("single_count", {29'd0, fifo_count}, 32'd1);
      busy_drop(t);
      check("single_busy_drop", t - k, 32'd42);
      wait_done("single");
      check("single_frames", frame_starts.size() - nf, 32'd1);
      check("single_tx_latency", (frame_starts.size() > nf) ? frame_starts[nf] - k : -1, 32'd3);

      // Held level: one capture only; data changes while still high.
      nf = frame_starts.size();
      maxc = 0;
      @(posedge clk); #1;
      response = 8'h3C;
      ready_to_read = 1'b1;
      sb_q.push_back(8'h3C);
      $display("capture 3c held at cycle %0d", cyc + 1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         response = 8'hFF;
         if (i == 2) begin
            ready_to_read = 1'b0;
            response = 8'h00;
         end
         if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      end
      check("held_count_peak", maxc, 32'd1);
      wait_done("held");
      check("held_frames", frame_starts.size() - nf, 32'd1);

      // Back-to-back: 01 goes straight out, 02..05 fill the queue.
      nf = frame_starts.size();
      send_burst(8'h01, 5, 5, k);
      @(negedge clk);
      check("b2b_count_full", {29'd0, fifo_count}, 32'd4);
      check("b2b_overflow", {31'd0, overflow}, 32'd0);
      wait_done("b2b");
      check("b2b_frames", frame_starts.size() - nf, 32'd5);
      for (int i = 1; i < 5; i++)
         check("b2b_gap", (frame_starts.size() >= nf + 5) ?
               frame_starts[nf+i] - frame_starts[nf+i-1] : -1, 32'd41);
      check("b2b_overflow_after", {31'd0, overflow}, 32'd0);

      // Overflow: 10 out, 11..14 queued, 15 dropped.
      nf = frame_starts.size();
      send_burst(8'h10, 6, 5, k);
      @(negedge clk);
      check("ovf_count_full", {29'd0, fifo_count}, 32'd4);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      wait_done("ovf");
      check("ovf_frames", frame_starts.size() - nf, 32'd5);
      check("ovf_flag_sticky", {31'd0, overflow}, 32'd1);

      // Reset during bit 3 of 8'hFF with two words queued.
      nf = frame_starts.size();
      send_burst(8'hFF, 1, 1, k);
      sb_q.push_back(8'h5A);
      sb_q.push_back(8'h66);
      @(posedge clk); #1;
      response = 8'h5A; ready_to_read = 1'b1;
      @(posedge clk); #1;
      ready_to_read = 1'b0;
      @(posedge clk); #1;
      response = 8'h66; ready_to_read = 1'b1;
      @(posedge clk); #1;
      ready_to_read = 1'b0; response = 8'h00;
      // Start bit sampled at k+3..k+6, bit 3 at k+19..k+22.
      for (int i = 0; i < 100 && cyc < k + 20; i++) @(negedge clk);
      check("rst_pre_count", {29'd0, fifo_count}, 32'd2);
      check("rst_pre_busy", {31'd0, busy}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("rst_async_tx", {31'd0, tx}, 32'd1);
      check("rst_async_count", {29'd0, fifo_count}, 32'd0);
      check("rst_async_busy", {31'd0, busy}, 32'd0);
      check("rst_async_overflow", {31'd0, overflow}, 32'd0);
      sb_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) seen = 1'b1;
      end
      check("rst_no_frame_tx", {31'd0, seen}, 32'd0);
      check("rst_no_frame", frame_starts.size() - nf, 32'd0);
      check("rst_after_busy", {31'd0, busy}, 32'd0);

`ifdef PUF_RESP_TX_PARITY_EN
      // 8E1: 07 has odd weight -> parity 1; 03 -> parity 0; 44-cycle frame.
      nf = parity_seen.size();
      send_one(8'h07, k);
      busy_drop(t);
      check("par_busy_drop", t - k, 32'd46);
      wait_done("par07");
      send_one(8'h03, k);
      wait_done("par03");
      check("par_07", (parity_seen.size() > nf) ? {31'd0, parity_seen[nf]} : 32'hFFFF_FFFF, 32'd1);
      check("par_03", (parity_seen.size() > nf + 1) ? {31'd0, parity_seen[nf+1]} : 32'hFFFF_FFFF, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
